// File: rtl/yutorina_if_prefetch_pkg.sv
// yutorina_if_prefetch_pkg: shared types and constants for the prefetching fetch stage
package yutorina_if_prefetch_pkg;
  localparam int ADDR_W_DEF = 30;
  localparam int DATA_W_DEF = 32;
  localparam logic [ADDR_W_DEF-1:0] RESET_PC_DEF = '0;
  localparam logic [ADDR_W_DEF-1:0] FLUSH_VEC_DEF = 30'd22;
  typedef struct packed {
    logic [ADDR_W_DEF-1:0] pc;
    logic [DATA_W_DEF-1:0] insn;
  } fetch_t;
  typedef enum logic [1:0] {REDIR_NONE, REDIR_BRANCH, REDIR_FLUSH} redir_e;
  function automatic redir_e redir_sel(input logic stall, input logic flush, input logic br_taken);
    return stall ? REDIR_NONE : flush ? REDIR_FLUSH : br_taken ? REDIR_BRANCH : REDIR_NONE;
  endfunction
endpackage

// File: rtl/yutorina_if_prefetch_if.sv
// yutorina_if_prefetch_if: ID-facing and memory-facing signals of the fetch stage
interface yutorina_if_prefetch_if
  import yutorina_if_prefetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic stall;
  logic flush;
  logic br_taken;
  logic [ADDR_W-1:0] br_addr;
  logic mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic mem_gnt;
  logic mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  logic [ADDR_W-1:0] if_pc;
  logic [DATA_W-1:0] if_insn;
  logic if_valid;
  logic busy;
  modport master (
    input stall, flush, br_taken, br_addr, mem_gnt, mem_rvalid, mem_rdata,
    output mem_req, mem_addr, if_pc, if_insn, if_valid, busy
  );
  modport slave (
    output stall, flush, br_taken, br_addr, mem_gnt, mem_rvalid, mem_rdata,
    input mem_req, mem_addr, if_pc, if_insn, if_valid, busy
  );
endinterface

// File: rtl/yutorina_sync_fifo.sv
// yutorina_sync_fifo: synchronous FIFO with clear, occupancy count and empty/full flags
module yutorina_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic push,
  input  logic pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic empty,
  output logic full
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic do_pop;
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign do_pop = pop && !empty;
  assign dout = mem[rptr];
  // storage needs no reset; the pointers decide which words are live
  always_ff @(posedge clk)
    if (push) mem[wptr] <= din;
  // pointer and occupancy bookkeeping, clear wins over push/pop
  always_ff @(posedge clk)
    if (rst || clear) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      wptr <= wptr + PW'(push);
      rptr <= rptr + PW'(do_pop);
      count <= count + CW'(push) - CW'(do_pop);
    end
  assert property (@(posedge clk) disable iff (rst) count <= CW'(DEPTH));
endmodule

// File: rtl/yutorina_if_prefetch.sv
// yutorina_if_prefetch: instruction fetch stage with a decoupled prefetch queue
module yutorina_if_prefetch
  import yutorina_if_prefetch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF,
  parameter logic [ADDR_W-1:0] FLUSH_VEC = FLUSH_VEC_DEF
) (
  input logic clk,
  input logic rst,
  yutorina_if_prefetch_if.master bus
);
  localparam int CW = $clog2(DEPTH+1);
  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] insn;
  } entry_t;
  redir_e redir;
  entry_t head;
  logic redirect, req, grant, drop, keep, pop;
  logic q_empty, q_full, tag_empty, tag_full;
  logic [ADDR_W-1:0] fpc, target, tag_head;
  logic [CW-1:0] count, outstanding, discard;
  logic [CW+1:0] inflight;
  assign redir = redir_sel(bus.stall, bus.flush, bus.br_taken);
  assign redirect = redir != REDIR_NONE;
  assign target = redir == REDIR_FLUSH ? FLUSH_VEC : bus.br_addr;
  assign inflight = (CW+2)'(count) + (CW+2)'(outstanding) + (CW+2)'(discard);
  assign req = !rst && !redirect && inflight < (CW+2)'(DEPTH) && !q_full && !tag_full;
  assign grant = req && bus.mem_gnt;
  assign drop = bus.mem_rvalid && discard != '0;
  assign keep = bus.mem_rvalid && discard == '0 && !tag_empty;
  assign pop = !bus.stall && !redirect && !q_empty;
  assign bus.mem_req = req;
  assign bus.mem_addr = fpc;
  assign bus.busy = q_empty && outstanding != '0;
  yutorina_sync_fifo #(.WIDTH(ADDR_W), .DEPTH(DEPTH)) u_tag (
    .clk(clk), .rst(rst), .clear(redirect), .push(grant), .pop(keep),
    .din(fpc), .dout(tag_head), .count(outstanding), .empty(tag_empty), .full(tag_full)
  );
  yutorina_sync_fifo #(.WIDTH(ADDR_W+DATA_W), .DEPTH(DEPTH)) u_queue (
    .clk(clk), .rst(rst), .clear(redirect), .push(keep), .pop(pop),
    .din({tag_head, bus.mem_rdata}), .dout(head), .count(count), .empty(q_empty), .full(q_full)
  );
  // fetch pointer: redirect target or advance on every accepted request
  always_ff @(posedge clk)
    fpc <= rst ? RESET_PC : redirect ? target : fpc + ADDR_W'(grant);
  // responses still owed for fetches abandoned by a redirect
  always_ff @(posedge clk)
    discard <= rst ? '0 : redirect ? discard + outstanding - CW'(drop || keep) : discard - CW'(drop);
  // present the queue head to ID unless stalled; a redirect blanks the slot
  always_ff @(posedge clk)
    if (rst) begin
      bus.if_pc <= '0;
      bus.if_insn <= '0;
      bus.if_valid <= 1'b0;
    end else if (redirect) begin
      bus.if_insn <= '0;
      bus.if_valid <= 1'b0;
    end else if (!bus.stall) begin
      bus.if_pc <= q_empty ? bus.if_pc : head.pc;
      bus.if_insn <= q_empty ? '0 : head.insn;
      bus.if_valid <= !q_empty;
    end
  assert property (@(posedge clk) disable iff (rst) bus.mem_rvalid |-> (outstanding != '0 || discard != '0));
endmodule

// File: tb/tb_yutorina_if_prefetch.sv
// tb_yutorina_if_prefetch: directed vector bench for the prefetching fetch stage
module tb_yutorina_if_prefetch;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic resp_en = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [29:0] pend[$];
  always #5 clk = ~clk;
  yutorina_if_prefetch_if #(.ADDR_W(30), .DATA_W(32)) b();
  yutorina_if_prefetch #(
    .ADDR_W(30), .DATA_W(32), .DEPTH(4), .RESET_PC(30'd0), .FLUSH_VEC(30'd22)
  ) dut (.clk(clk), .rst(rst), .bus(b));

  typedef struct {
    logic rs;
    logic g;
    logic re;
    logic req;
    logic [29:0] addr;
    logic busy;
    logic valid;
    logic [29:0] pc;
    logic [31:0] insn;
  } vec_t;
  vec_t tbl[$];

  function automatic logic [31:0] insn_of(input logic [29:0] a);
    return {2'b01, a};
  endfunction

  function automatic vec_t mk(input logic rs, g, re, req, input logic [29:0] addr,
                              input logic busy, valid, input logic [29:0] pc, input logic [31:0] insn);
    vec_t v;
    v.rs = rs; v.g = g; v.re = re; v.req = req; v.addr = addr;
    v.busy = busy; v.valid = valid; v.pc = pc; v.insn = insn;
    return v;
  endfunction

  // memory model: records granted addresses, answers one per cycle, in order, one cycle later
  always @(posedge clk)
    if (b.mem_req && b.mem_gnt) pend.push_back(b.mem_addr);
  always @(negedge clk) begin
    #1;
    if (resp_en && pend.size() > 0) begin
      b.mem_rvalid = 1'b1;
      b.mem_rdata = insn_of(pend.pop_front());
    end else begin
      b.mem_rvalid = 1'b0;
      b.mem_rdata = '0;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic st, fl, br, input logic [29:0] ba, input logic g, re);
    @(negedge clk);
    rst = 1'b0;
    b.stall = st;
    b.flush = fl;
    b.br_taken = br;
    b.br_addr = ba;
    b.mem_gnt = g;
    resp_en = re;
    #2;
  endtask

  task automatic do_reset();
    repeat (6) begin
      @(negedge clk);
      rst = 1'b1;
      b.stall = 1'b0;
      b.flush = 1'b0;
      b.br_taken = 1'b0;
      b.br_addr = '0;
      b.mem_gnt = 1'b0;
      resp_en = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic seen;
    b.stall = 1'b0;
    b.flush = 1'b0;
    b.br_taken = 1'b0;
    b.br_addr = '0;
    b.mem_gnt = 1'b0;
    // streaming fetch with one-cycle memory latency
    tbl.push_back(mk(1, 1, 1, 1, 30'd0, 0, 0, 30'd0, 32'h0));
    tbl.push_back(mk(0, 1, 1, 1, 30'd1, 1, 0, 30'd0, 32'h0));
    tbl.push_back(mk(0, 1, 1, 1, 30'd2, 0, 0, 30'd0, 32'h0));
    tbl.push_back(mk(0, 1, 1, 1, 30'd3, 0, 1, 30'd0, 32'h4000_0000));
    tbl.push_back(mk(0, 1, 1, 1, 30'd4, 0, 1, 30'd1, 32'h4000_0001));
    tbl.push_back(mk(0, 1, 1, 1, 30'd5, 0, 1, 30'd2, 32'h4000_0002));
    // responses withheld: four requests then back-pressure, release resumes issue
    tbl.push_back(mk(1, 1, 0, 1, 30'd0, 0, 0, 30'd0, 32'h0));
    tbl.push_back(mk(0, 1, 0, 1, 30'd1, 1, 0, 30'd0, 32'h0));
    tbl.push_back(mk(0, 1, 0, 1, 30'd2, 1, 0, 30'd0, 32'h0));
    tbl.push_back(mk(0, 1, 0, 1, 30'd3, 1, 0, 30'd0, 32'h0));
    tbl.push_back(mk(0, 1, 0, 0, 30'd4, 1, 0, 30'd0, 32'h0));
    tbl.push_back(mk(0, 1, 1, 0, 30'd4, 1, 0, 30'd0, 32'h0));
    tbl.push_back(mk(0, 1, 1, 0, 30'd4, 0, 0, 30'd0, 32'h0));
    tbl.push_back(mk(0, 1, 1, 1, 30'd4, 0, 1, 30'd0, 32'h4000_0000));
    tbl.push_back(mk(0, 1, 1, 1, 30'd5, 0, 1, 30'd1, 32'h4000_0001));
    foreach (tbl[i]) begin
      if (tbl[i].rs) do_reset();
      cyc(0, 0, 0, '0, tbl[i].g, tbl[i].re);
      chk($sformatf("row%0d mem_req", i), b.mem_req, tbl[i].req);
      chk($sformatf("row%0d mem_addr", i), b.mem_addr, tbl[i].addr);
      chk($sformatf("row%0d busy", i), b.busy, tbl[i].busy);
      chk($sformatf("row%0d if_valid", i), b.if_valid, tbl[i].valid);
      chk($sformatf("row%0d if_pc", i), b.if_pc, tbl[i].pc);
      chk($sformatf("row%0d if_insn", i), b.if_insn, tbl[i].insn);
    end

    // stall for 5 cycles while data keeps arriving
    do_reset();
    repeat (4) cyc(0, 0, 0, '0, 1, 1);
    chk("pre-stall pc", b.if_pc, 30'd0);
    for (int k = 0; k < 5; k++) begin
      cyc(1, 0, 0, '0, 1, 1);
      chk($sformatf("stall%0d if_pc", k), b.if_pc, 30'd1);
      chk($sformatf("stall%0d if_insn", k), b.if_insn, 32'h4000_0001);
      chk($sformatf("stall%0d if_valid", k), b.if_valid, 1'b1);
      if (k >= 2) chk($sformatf("stall%0d mem_req", k), b.mem_req, 1'b0);
    end
    cyc(0, 0, 0, '0, 1, 1);
    chk("release mem_req", b.mem_req, 1'b0);
    chk("release if_pc", b.if_pc, 30'd1);
    for (int k = 0; k < 4; k++) begin
      cyc(0, 0, 0, '0, 1, 1);
      chk($sformatf("drain%0d if_valid", k), b.if_valid, 1'b1);
      chk($sformatf("drain%0d if_pc", k), b.if_pc, 30'(2 + k));
      chk($sformatf("drain%0d if_insn", k), b.if_insn, insn_of(30'(2 + k)));
    end

    // branch with three fetches in flight
    do_reset();
    repeat (3) cyc(0, 0, 0, '0, 1, 0);
    cyc(0, 0, 1, 30'h100, 1, 1);
    chk("br cycle mem_req", b.mem_req, 1'b0);
    cyc(0, 0, 0, '0, 1, 1);
    chk("br target mem_req", b.mem_req, 1'b1);
    chk("br target mem_addr", b.mem_addr, 30'h100);
    cyc(0, 0, 0, '0, 1, 1);
    chk("br next mem_addr", b.mem_addr, 30'h101);
    chk("br stale if_valid", b.if_valid, 1'b0);
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      cyc(0, 0, 0, '0, 1, 1);
      seen = b.if_valid;
    end
    chk("br if_valid seen", seen, 1'b1);
    chk("br first if_pc", b.if_pc, 30'h100);
    chk("br first if_insn", b.if_insn, insn_of(30'h100));

    // redirect under stall is held off; flush beats branch
    do_reset();
    cyc(1, 0, 1, 30'h100, 0, 0);
    chk("stalled br mem_req", b.mem_req, 1'b1);
    chk("stalled br mem_addr", b.mem_addr, 30'd0);
    cyc(0, 0, 1, 30'h100, 0, 0);
    chk("br redirect mem_req", b.mem_req, 1'b0);
    cyc(0, 0, 0, '0, 0, 0);
    chk("br applied mem_addr", b.mem_addr, 30'h100);
    do_reset();
    cyc(0, 1, 1, 30'h100, 1, 0);
    chk("flush cycle mem_req", b.mem_req, 1'b0);
    cyc(0, 0, 0, '0, 1, 0);
    chk("flush mem_req", b.mem_req, 1'b1);
    chk("flush mem_addr", b.mem_addr, 30'd22);

    // reset with two fetches outstanding, late responses land during reset
    do_reset();
    repeat (2) cyc(0, 0, 0, '0, 1, 0);
    cyc(0, 0, 0, '0, 0, 0);
    chk("pre-rst mem_addr", b.mem_addr, 30'd2);
    chk("pre-rst busy", b.busy, 1'b1);
    repeat (3) begin
      @(negedge clk);
      rst = 1'b1;
      b.mem_gnt = 1'b1;
      resp_en = 1'b1;
      #2;
      chk("in-rst mem_req", b.mem_req, 1'b0);
    end
    cyc(0, 0, 0, '0, 0, 1);
    chk("post-rst mem_addr", b.mem_addr, 30'd0);
    chk("post-rst mem_req", b.mem_req, 1'b1);
    chk("post-rst busy", b.busy, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cyc(0, 0, 0, '0, 0, 1);
      chk($sformatf("post-rst%0d if_valid", k), b.if_valid, 1'b0);
    end
    cyc(0, 0, 0, '0, 1, 1);
    chk("post-rst grant addr", b.mem_addr, 30'd0);
    cyc(0, 0, 0, '0, 0, 1);
    chk("post-rst next addr", b.mem_addr, 30'd1);

    // fetch address wraps at the top of the address space
    do_reset();
    cyc(0, 0, 1, 30'h3FFF_FFFF, 0, 0);
    cyc(0, 0, 0, '0, 1, 0);
    chk("wrap top mem_addr", b.mem_addr, 30'h3FFF_FFFF);
    chk("wrap top mem_req", b.mem_req, 1'b1);
    cyc(0, 0, 0, '0, 0, 0);
    chk("wrap mem_addr", b.mem_addr, 30'd0);
    do_reset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
